usb_tx: RTL

USB_TX -- requirements
Module: usb_tx

---
 rtl/usb_pkg.sv | 23 ++
 rtl/usb_tx_if.sv | 31 +++
 rtl/byte_fifo.sv | 64 ++++++
 rtl/usb_tx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the FT245 USB transmit path: FSM states, default
// sizing and the FT245 pin polarities also used by the receiver.
package usb_pkg;

  localparam int unsigned DEF_DEPTH    = 16;
  localparam int unsigned DEF_WR_PULSE = 3;
  localparam int unsigned DEF_SI_IDLE  = 1024;

  localparam logic TXE_SPACE    = 1'b0;
  localparam logic TXE_NO_SPACE = 1'b1;
  localparam logic WR_ACTIVE    = 1'b1;
  localparam logic SI_ACTIVE    = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETUP,
    STROBE,
    HOLD,
    SI_PULSE
  } tx_state_e;

endpackage

// File: rtl/usb_tx_if.sv
// Byte handshake, flush, FT245 pins and shared d-bus arbitration of usb_tx.
interface usb_tx_if
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
);

  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   flush;
  logic                   txe;
  logic                   bus_req;
  logic                   bus_gnt;
  logic                   wr;
  logic [7:0]             d_out;
  logic                   d_oe;
  logic                   SI;
  logic [$clog2(DEPTH):0] level;

  modport slave (
    input  tx_data, tx_valid, flush, txe, bus_gnt,
    output tx_ready, bus_req, wr, d_out, d_oe, SI, level
  );

  modport master (
    output tx_data, tx_valid, flush, txe, bus_gnt,
    input  tx_ready, bus_req, wr, d_out, d_oe, SI, level
  );

endinterface

// File: rtl/byte_fifo.sv
// Circular byte FIFO with registered full/empty/level flags.
module byte_fifo
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [7:0]             din_i,
  input  logic                   pop_i,
  output logic [7:0]             dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          full_q;
  logic          empty_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // Simultaneous push and pop leaves the level untouched.
  always_comb begin
    level_d = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/usb_tx.sv
// FT245 transmit engine: buffers bytes, arbitrates for the shared d bus,
// strobes wr per byte and issues send-immediate on flush or idle timeout.
module usb_tx
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned WR_PULSE = DEF_WR_PULSE,
  parameter int unsigned SI_IDLE  = DEF_SI_IDLE
) (
  input logic     clk,
  input logic     rst_n,
  usb_tx_if.slave bus
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned PC_W  = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam int unsigned IC_W  = $clog2(SI_IDLE + 1);
  // HOLD cycle, trigger decision and output register absorb three cycles.
  localparam int unsigned IDLE_TRIG = SI_IDLE - 3;

  tx_state_e        state_q, state_d;
  logic [PC_W-1:0]  pcnt_q, pcnt_d;
  logic [IC_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic             armed_q, armed_d;
  logic             pending_q, pending_d;
  logic             txe_meta_q, txe_s_q;
  logic             bus_req_q, bus_req_d;
  logic             wr_q, wr_d;
  logic             d_oe_q, d_oe_d;
  logic [7:0]       d_out_q, d_out_d;
  logic             si_q, si_d;

  logic             push, pop, full, empty, pulse_last, si_trig, enter_si, space;
  logic [7:0]       fifo_head;
  logic [LVL_W-1:0] level;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (bus.tx_data),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign push       = bus.tx_valid && !full;
  assign pulse_last = (pcnt_q == PC_W'(WR_PULSE - 1));
  assign pop        = (state_q == STROBE) && pulse_last;
  assign space      = (txe_s_q == TXE_SPACE);
  assign si_trig    = armed_q && (idle_cnt_q == IC_W'(IDLE_TRIG));
  assign enter_si   = (state_q != SI_PULSE) && (state_d == SI_PULSE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txe_meta_q <= TXE_NO_SPACE;
      txe_s_q    <= TXE_NO_SPACE;
    end else begin
      txe_meta_q <= bus.txe;
      txe_s_q    <= txe_meta_q;
    end
  end

  // State, counters and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      idle_cnt_q <= '0;
      armed_q    <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      idle_cnt_q <= idle_cnt_d;
      armed_q    <= armed_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (!empty && space)                  state_d = REQ;
        else if (empty && (pending_q || si_trig)) state_d = SI_PULSE;
      end
      REQ: begin
        if (!space)           state_d = IDLE;
        else if (bus.bus_gnt) state_d = SETUP;
      end
      SETUP: state_d = STROBE;
      STROBE: begin
        if (pulse_last) state_d = HOLD;
        else            pcnt_d  = pcnt_q + PC_W'(1);
      end
      HOLD: begin
        if (!empty && space && bus.bus_gnt) state_d = SETUP;
        else                                state_d = IDLE;
      end
      SI_PULSE: begin
        if (pulse_last) state_d = IDLE;
        else            pcnt_d  = pcnt_q + PC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle timer re-arms on every pop; a flush arriving mid-pulse survives the clear.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    armed_d    = armed_q;
    pending_d  = pending_q;
    if (pop) begin
      idle_cnt_d = '0;
      armed_d    = 1'b1;
    end else if (state_q == IDLE && empty && idle_cnt_q != IC_W'(SI_IDLE)) begin
      idle_cnt_d = idle_cnt_q + IC_W'(1);
    end
    if (enter_si) begin
      armed_d   = 1'b0;
      pending_d = 1'b0;
    end
    if (bus.flush) pending_d = 1'b1;
  end

  always_comb begin
    bus_req_d = 1'b0;
    wr_d      = !WR_ACTIVE;
    d_oe_d    = 1'b0;
    d_out_d   = d_out_q;
    si_d      = !SI_ACTIVE;
    case (state_q)
      REQ:    bus_req_d = 1'b1;
      SETUP: begin
        bus_req_d = 1'b1;
        d_oe_d    = 1'b1;
        d_out_d   = fifo_head;
      end
      STROBE: begin
        bus_req_d = 1'b1;
        d_oe_d    = 1'b1;
        wr_d      = WR_ACTIVE;
      end
      HOLD: begin
        bus_req_d = 1'b1;
        d_oe_d    = 1'b1;
      end
      SI_PULSE: si_d = SI_ACTIVE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_q <= 1'b0;
      wr_q      <= !WR_ACTIVE;
      d_oe_q    <= 1'b0;
      d_out_q   <= '0;
      si_q      <= !SI_ACTIVE;
    end else begin
      bus_req_q <= bus_req_d;
      wr_q      <= wr_d;
      d_oe_q    <= d_oe_d;
      d_out_q   <= d_out_d;
      si_q      <= si_d;
    end
  end

  assign bus.tx_ready = !full;
  assign bus.bus_req  = bus_req_q;
  assign bus.wr       = wr_q;
  assign bus.d_out    = d_out_q;
  assign bus.d_oe     = d_oe_q;
  assign bus.SI       = si_q;
  assign bus.level    = level;

endmodule
